key_debounce_latch: RTL
=======================

KEY_DEBOUNCE_LATCH -- requirements
Module: key_debounce_latch

Interface
REQ-001 Parameter DB_CYCLES, default 50000, number of consecutive stable samples required to accept a new key level; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, width of each per-key debounce counter; SHALL satisfy 2**CNT_W > DB_CYCLES.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_raw  input  4  raw, asynchronous, bouncing push-button levels; 1 = pressed.
REQ-006 clr  input  1  one-cycle strobe from the bus side acknowledging events.
REQ-007 clr_mask  input  4  per-key select for clr; bit i clears key i.
REQ-008 porta_out  output  4  sticky press-event flags; feeds the 4-bit input port of the data-memory/IO stage.
REQ-009 level_out  output  4  debounced key levels.
REQ-010 overrun  output  4  sticky flag per key: a press was lost while its event flag was still set.
REQ-011 any_event  output  1  OR of all porta_out bits.

Function
REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use; no logic SHALL read btn_raw directly.
REQ-013 Each key SHALL hold a stable level register L and a counter C of CNT_W bits.
REQ-014 If s2 == L, C SHALL load 0 on the next edge.
REQ-015 If s2 != L and C < DB_CYCLES-1, C SHALL increment by 1.
REQ-016 If s2 != L and C == DB_CYCLES-1, L SHALL load s2 and C SHALL load 0 on the same edge.
REQ-017 A single sample with s2 == L before the count completes SHALL restart the count from 0, so a glitch shorter than DB_CYCLES samples never changes L.
REQ-018 Latency: a clean raw level change SHALL appear on level_out exactly DB_CYCLES+2 rising edges after the first edge that samples it into s1.
REQ-019 C SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-020 An L transition 0->1 SHALL set porta_out[i] on the same edge that L changes. An L transition 1->0 SHALL produce no event.
REQ-021 porta_out[i] SHALL stay set until an edge with clr=1 and clr_mask[i]=1. That edge SHALL clear it, and the cleared value SHALL be visible after the edge.
REQ-022 If a set and a clear coincide for key i on the same edge, the set SHALL win: porta_out[i] stays 1 and overrun[i] is unaffected.
REQ-023 A 0->1 L transition while porta_out[i] is already 1 and not being cleared on that edge SHALL set overrun[i].
REQ-024 overrun[i] SHALL clear under the same clr/clr_mask condition as porta_out[i]. If a new overrun condition coincides with that clear, it SHALL remain set.
REQ-025 clr with clr_mask=0, or clr_mask with clr=0, SHALL change no state.
REQ-026 Keys SHALL be fully independent; simultaneous activity on several keys SHALL yield the same per-key results as isolated activity.
REQ-027 All outputs SHALL be driven directly from registers, except any_event, which is a combinational OR of the porta_out registers.

Reset
REQ-028 While rst_n=0, the following SHALL hold 0 immediately, independent of clk: s1, s2, L, C, porta_out, level_out, overrun and any_event.
REQ-029 Reset assertion in the middle of a debounce count SHALL discard the count.
REQ-030 After deassertion, a key held pressed SHALL be treated as a new 0->1 press: it sets porta_out DB_CYCLES+2 edges after release of reset.
REQ-031 rst_n deassertion is assumed synchronous to clk by the system; no internal reset synchronizer is required.

Verification (DB_CYCLES=4 for all scenarios)
REQ-032 Clean press: btn_raw[0] 0->1, then held -> level_out[0]=1 and porta_out[0]=1 exactly 6 edges later; any_event=1.
REQ-033 Bounce: btn_raw[1] high 3 cycles, low 1 cycle, high 3 cycles, then low -> level_out[1] and porta_out[1] stay 0 throughout.
REQ-034 Ack: with porta_out=4'b0101, pulse clr=1 with clr_mask=4'b0001 -> porta_out=4'b0100 after the edge; a pulse with clr=0 and mask=4'b1111 changes nothing.
REQ-035 Overrun and collision:
- Two debounced presses of key 2 with no clr in between -> overrun[2]=1.
- A later press whose set edge coincides with clr, mask=4'b0100 -> porta_out[2]=1 and overrun[2]=1 (set wins).
REQ-036 Reset mid-count: btn_raw[3]=1, then after 3 edges rst_n=0 for 2 cycles, then rst_n=1 with the key still held -> all outputs 0 during reset; porta_out[3]=1 exactly 6 edges after deassertion.
REQ-037 Release: a key held 1 then released cleanly -> level_out returns to 0 after 6 edges; porta_out is unchanged and no overrun occurs.

Source files
------------

// File: rtl/key_debounce_latch.sv
`default_nettype none
// ====================================================================
// key_debounce_latch : 4-key debouncer with sticky press/overrun flags
// Revision 1.0
// ====================================================================
module key_debounce_latch #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       clr,
  input  logic [3:0] clr_mask,
  output logic [3:0] porta_out,
  output logic [3:0] level_out,
  output logic [3:0] overrun,
  output logic       any_event
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);

  logic [3:0] r_s1;
  logic [3:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_evt;
    logic             r_ovr;
    logic             w_rise;
    logic             w_clr;

    assign w_rise = r_s2[gi] && !r_level && (r_cnt == c_cnt_last);
    assign w_clr  = clr && clr_mask[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_evt   <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        if (r_s2[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_level <= r_s2[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end

        // A new press beats a simultaneous acknowledge; overrun then holds.
        if (w_rise) begin
          r_evt <= 1'b1;
          if (r_evt && !w_clr) r_ovr <= 1'b1;
        end else if (w_clr) begin
          r_evt <= 1'b0;
          r_ovr <= 1'b0;
        end
      end
    end

    assign level_out[gi] = r_level;
    assign porta_out[gi] = r_evt;
    assign overrun[gi]   = r_ovr;
  end

  assign any_event = |porta_out;

endmodule
`default_nettype wire
